// File: rtl/clk_bringup_seq.sv
// clk_bringup_seq: clkgen then pixel-MMCM reset/lock sequencer; CLK_BRINGUP_LOSS_CNT_EN adds loss_count
module clk_bringup_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       pix_en,
  input  logic       pll_locked,
  input  logic       mig_pix_clkgen_locked,
  output logic       reset_pixdcm,
  output logic       mig_pix_clkgen_reset,
  output logic       logic_rst,
  output logic       clocks_ready,
  output logic       fault,
`ifdef CLK_BRINGUP_LOSS_CNT_EN
  output logic [7:0] loss_count,
`endif
  output logic [2:0] seq_state,
  output logic [3:0] retry_count
);
  typedef enum logic [2:0] {RST_SYS, WAIT_SYS, RST_PIX, WAIT_PIX, SETTLE, RUN, FAULT} state_t;
  localparam int MAXC = RST_CYCLES > LOCK_TIMEOUT ? (RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES)
                                                  : (LOCK_TIMEOUT > SETTLE_CYCLES ? LOCK_TIMEOUT : SETTLE_CYCLES);
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] R_END = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] T_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] S_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);
  state_t state, state_n, adv;
  logic [CW-1:0] cnt;
  logic [1:0] mig_s, pix_s;
  logic [3:0] retry_n;
  logic mig_lk, pix_lk, mig_loss, pix_loss, tmo;
  assign mig_lk = mig_s[1];
  assign pix_lk = pix_s[1];
  assign seq_state = state;
  // pix_lk low is only a loss once the lock has been seen, i.e. in SETTLE/RUN
  assign mig_loss = state inside {WAIT_PIX, SETTLE, RUN} && !mig_lk;
  assign pix_loss = (state inside {SETTLE, RUN} && !pix_lk) || (state inside {WAIT_PIX, SETTLE, RUN} && !pix_en);
  assign tmo = ((state == WAIT_SYS && !mig_lk) || (state == WAIT_PIX && !pix_lk)) && cnt >= T_END;
  assign adv = state == RST_SYS  ? (cnt >= R_END ? WAIT_SYS : RST_SYS) :
               state == WAIT_SYS ? (mig_lk ? RST_PIX : WAIT_SYS) :
               state == RST_PIX  ? (cnt >= R_END && pix_en ? WAIT_PIX : RST_PIX) :
               state == WAIT_PIX ? (pix_lk ? SETTLE : WAIT_PIX) :
               state == SETTLE   ? (cnt >= S_END ? RUN : SETTLE) : state;
  always_comb begin
    state_n = adv;
    retry_n = retry_count;
    if (restart) begin
      state_n = RST_SYS;
      retry_n = '0;
    end else if (mig_loss) state_n = RST_SYS;
    else if (pix_loss) state_n = RST_PIX;
    else if (tmo) begin
      retry_n = retry_count + 4'd1;
      state_n = retry_n == 4'(MAX_RETRIES) ? FAULT : state == WAIT_SYS ? RST_SYS : RST_PIX;
    end else if (adv == RUN) retry_n = '0;
  end
  // lock synchronizers are held clear while their MMCM is in reset so a stale lock cannot advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= RST_SYS;
      cnt                  <= '0;
      retry_count          <= '0;
      mig_s                <= '0;
      pix_s                <= '0;
      reset_pixdcm         <= 1'b1;
      mig_pix_clkgen_reset <= 1'b1;
      logic_rst            <= 1'b1;
      clocks_ready         <= 1'b0;
      fault                <= 1'b0;
    end else begin
      state                <= state_n;
      cnt                  <= (state_n != state || restart) ? '0 : &cnt ? cnt : cnt + ONE;
      retry_count          <= retry_n;
      mig_s                <= mig_pix_clkgen_reset ? 2'b00 : {mig_s[0], mig_pix_clkgen_locked};
      pix_s                <= reset_pixdcm ? 2'b00 : {pix_s[0], pll_locked};
      mig_pix_clkgen_reset <= state_n inside {RST_SYS, FAULT};
      reset_pixdcm         <= state_n inside {RST_SYS, WAIT_SYS, RST_PIX, FAULT};
      logic_rst            <= state_n != RUN;
      clocks_ready         <= state_n == RUN;
      fault                <= state_n == FAULT;
    end
  end
`ifdef CLK_BRINGUP_LOSS_CNT_EN
  logic loss_evt;
  assign loss_evt = state inside {SETTLE, RUN} && !restart && (mig_loss || pix_loss);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) loss_count <= '0;
    else if (restart) loss_count <= '0;
    else if (loss_evt && !(&loss_count)) loss_count <= loss_count + 8'd1;
  end
`endif
endmodule
